// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake and operand/result bus between the EX stage and the mul/div unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: magnitude-based shift-add multiply and restoring
// divide, with sign correction and the RISC-V divide-by-zero/overflow results applied in FIX.
module muldiv_unit #(
    parameter int unsigned XLEN          = 32,
    parameter bit          MUL_ITERATIVE = 1'b0
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned     CW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic              div_zero_q, div_zero_d, ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            accept, signed_a, signed_b, in_sign_a, in_sign_b;
    logic            in_div_zero, in_ovf, in_fast;
    logic [XLEN-1:0] in_mag_a, in_mag_b;

    always_comb begin
        accept      = ((state_q == StIdle) || (state_q == StDone)) && bus.start && !bus.flush;
        signed_a    = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op[2] && !bus.op[0]);
        signed_b    = (bus.op == 3'b001) || (bus.op[2] && !bus.op[0]);
        in_sign_a   = signed_a && bus.operand_a[XLEN-1];
        in_sign_b   = signed_b && bus.operand_b[XLEN-1];
        in_mag_a    = in_sign_a ? -bus.operand_a : bus.operand_a;
        in_mag_b    = in_sign_b ? -bus.operand_b : bus.operand_b;
        in_div_zero = bus.op[2] && (bus.operand_b == '0);
        in_ovf      = bus.op[2] && !bus.op[0] && (bus.operand_a == MinVal) && (bus.operand_b == '1);
        in_fast     = (!bus.op[2] && !MUL_ITERATIVE) || in_div_zero || in_ovf;
    end

    // One iteration of shift-add multiply (carry kept in bit XLEN) and restoring divide.
    logic [XLEN-1:0] mul_add, rem_next;
    logic [XLEN:0]   mul_sum, rem_sh, rem_sub;
    logic            q_bit;

    always_comb begin
        mul_add  = acc_q[0] ? mag_a_q : '0;
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add};
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_sub  = rem_sh - {1'b0, mag_b_q};
        q_bit    = rem_sh >= {1'b0, mag_b_q};
        rem_next = q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    end

    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;
    logic              neg;

    always_comb begin
        neg    = sign_a_q ^ sign_b_q;
        prod   = MUL_ITERATIVE ? acc_q
                               : {{XLEN{1'b0}}, mag_a_q} * {{XLEN{1'b0}}, mag_b_q};
        prod_s = neg ? -prod : prod;
        if (div_zero_q) begin
            quo_s = '1;
            rem_s = sign_a_q ? -mag_a_q : mag_a_q;
        end else if (ovf_q) begin
            quo_s = mag_a_q;
            rem_s = '0;
        end else begin
            quo_s = neg ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            rem_s = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end
        case (op_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_s;
            default:                fix_res = rem_s;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        result_d   = result_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    op_d       = bus.op;
                    mag_a_d    = in_mag_a;
                    mag_b_d    = in_mag_b;
                    sign_a_d   = in_sign_a;
                    sign_b_d   = in_sign_b;
                    div_zero_d = in_div_zero;
                    ovf_d      = in_ovf;
                    cnt_d      = '0;
                    acc_d      = bus.op[2] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
                    state_d    = in_fast ? StFix : StCalc;
                end
            end
            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = op_q[2] ? {rem_next, acc_q[XLEN-2:0], q_bit}
                                    : {mul_sum, acc_q[XLEN-1:1]};
                    if (cnt_q == CW'(XLEN - 1)) begin
                        cnt_d   = '0;
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StFix: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    result_d = fix_res;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
        end
    end

    assign bus.busy   = (state_q == StCalc) || (state_q == StFix);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: the same stimulus drives a combinational-multiply and an iterative-multiply
// instance; results and latencies are checked against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
    localparam int unsigned XLEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic [31:0] prev;
    int          n_cmp = 0;
    int          n_fail = 0;

    muldiv_unit_if #(.XLEN(XLEN)) bus0 ();
    muldiv_unit_if #(.XLEN(XLEN)) bus1 ();

    assign bus0.start = start;
    assign bus0.op = op;
    assign bus0.operand_a = opa;
    assign bus0.operand_b = opb;
    assign bus0.flush = flush;
    assign bus1.start = start;
    assign bus1.op = op;
    assign bus1.operand_a = opa;
    assign bus1.operand_b = opb;
    assign bus1.flush = flush;

    muldiv_unit #(.XLEN(XLEN), .MUL_ITERATIVE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    muldiv_unit #(.XLEN(XLEN), .MUL_ITERATIVE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, required finish within 2 ms");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          ia, ib;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input bit iter, input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        bit fast;
        fast = (!f[2] && !iter) || (f[2] && b == 0) ||
               (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return fast ? 2 : XLEN + 2;
    endfunction

    // Issues one op (START sampled at edge 0), optionally pokes START mid-flight at cycle 'poke'.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input string tag);
        logic [31:0] exp_r, r0, r1;
        int          l0, l1, b0, b1, e0, e1;
        exp_r = ref_model(f, a, b);
        e0 = exp_lat(1'b0, f, a, b);
        e1 = exp_lat(1'b1, f, a, b);
        l0 = -1; l1 = -1; b0 = 0; b1 = 0; r0 = '0; r1 = '0;
        start = 1'b1; op = f; opa = a; opb = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; opa = $urandom; opb = $urandom; op = 3'($urandom);
        for (int cyc = 1; cyc <= int'(XLEN) + 8; cyc++) begin
            if (l0 < 0) begin
                if (bus0.done) begin l0 = cyc; r0 = bus0.result; end
                else if (bus0.busy) b0++;
            end
            if (l1 < 0) begin
                if (bus1.done) begin l1 = cyc; r1 = bus1.result; end
                else if (bus1.busy) b1++;
            end
            if (l0 >= 0 && l1 >= 0) break;
            if (cyc == poke) begin
                start = 1'b1; op = 3'b000; opa = 32'd3; opb = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("%s result u0", tag), r0, exp_r);
        check($sformatf("%s result u1", tag), r1, exp_r);
        check($sformatf("%s latency u0", tag), 32'(l0), 32'(e0));
        check($sformatf("%s latency u1", tag), 32'(l1), 32'(e1));
        check($sformatf("%s busy cycles u0", tag), 32'(b0), 32'(e0 - 1));
        check($sformatf("%s busy cycles u1", tag), 32'(b1), 32'(e1 - 1));
        prev = exp_r;
    endtask

    task automatic check_quiet(input string tag, input logic [31:0] res);
        check($sformatf("%s busy u0", tag), 32'(bus0.busy), 32'd0);
        check($sformatf("%s busy u1", tag), 32'(bus1.busy), 32'd0);
        check($sformatf("%s done u0", tag), 32'(bus0.done), 32'd0);
        check($sformatf("%s done u1", tag), 32'(bus1.done), 32'd0);
        check($sformatf("%s result u0", tag), bus0.result, res);
        check($sformatf("%s result u1", tag), bus1.result, res);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; opa = '0; opb = '0; prev = '0;
        repeat (2) @(negedge clk);
        check_quiet("reset", 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5, "div start-while-busy");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem");
        run_op(3'd5, 32'd100, 32'd7, 12, "divu start-while-busy");
        run_op(3'd7, 32'd100, 32'd7, 0, "remu");
        run_op(3'd4, 32'd5, 32'd0, 0, "div by zero");
        run_op(3'd7, 32'd5, 32'd0, 0, "remu by zero");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div overflow");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem overflow");
        run_op(3'd5, 32'd100, 32'd7, 0, "divu before flush");

        // Flush mid-divide: no DONE, result keeps the previous value.
        start = 1'b1; op = 3'd4; opa = 32'd1000; opb = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_quiet("flush", prev);
        run_op(3'd5, 32'd1000, 32'd3, 0, "after flush");

        // START together with FLUSH is ignored.
        start = 1'b1; flush = 1'b1; op = 3'd4; opa = 32'd9; opb = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_quiet("start with flush", prev);

        // Asynchronous reset mid-CALC.
        start = 1'b1; op = 3'd5; opa = $urandom; opb = $urandom | 32'h1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_quiet("async reset", 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(3'd5, $urandom, $urandom | 32'h1, 0, "b2b divu 1");
        run_op(3'd5, $urandom, $urandom | 32'h1, 0, "b2b divu 2");

        for (int i = 0; i < 30; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(rf, ra, rb, 0, $sformatf("random %0d op%0d", i, rf));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
